// File: rtl/udma_hyper_sched.sv
// HyperBus transfer scheduler: picks a descriptor round-robin, programs the
// uDMA channel config registers, then waits for end-of-transfer or timeout.
//
// state    | meaning
// IDLE     | no transfer; arbitrate and accept one descriptor
// WR_EXT   | config write: external memory address
// WR_L2    | config write: L2 address
// WR_SIZE  | config write: byte count
// WR_CMD   | config write: start + direction
// WAIT_EOT | waiting for eot_i, timeout counter running
// DONE     | completion; pulses issued and last_q updated
module udma_hyper_sched #(
    parameter int unsigned NB_REQ     = 2,
    parameter int unsigned TRANS_SIZE = 16,
    parameter int unsigned TMO_W      = 16,
    parameter logic [4:0]  A_EXT      = 5'h00,
    parameter logic [4:0]  A_L2       = 5'h01,
    parameter logic [4:0]  A_SIZE     = 5'h02,
    parameter logic [4:0]  A_CMD      = 5'h03
) (
    input  logic                              sys_clk_i,
    input  logic                              rstn_i,
    input  logic [NB_REQ-1:0]                 req_valid_i,
    output logic [NB_REQ-1:0]                 req_ready_o,
    input  logic [NB_REQ-1:0][31:0]           req_ext_addr_i,
    input  logic [NB_REQ-1:0][31:0]           req_l2_addr_i,
    input  logic [NB_REQ-1:0][TRANS_SIZE-1:0] req_size_i,
    input  logic [NB_REQ-1:0]                 req_rwn_i,
    output logic [4:0]                        cfg_addr_o,
    output logic [31:0]                       cfg_data_o,
    output logic                              cfg_valid_o,
    output logic                              cfg_rwn_o,
    input  logic                              cfg_ready_i,
    input  logic                              eot_i,
    output logic [NB_REQ-1:0]                 done_o,
    output logic                              done_rd_o,
    output logic                              done_wr_o,
    output logic                              err_o,
    output logic                              busy_o
);
    localparam int unsigned IW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE, WR_EXT, WR_L2, WR_SIZE, WR_CMD, WAIT_EOT, DONE
    } state_t;

    state_t                state_q;
    logic [IW-1:0]         last_q;
    logic [IW-1:0]         idx_q;
    logic [31:0]           ext_q;
    logic [31:0]           l2_q;
    logic [TRANS_SIZE-1:0] size_q;
    logic                  rwn_q;
    logic [TMO_W-1:0]      cnt_q;
    logic [NB_REQ-1:0]     done_q;
    logic                  done_rd_q;
    logic                  done_wr_q;
    logic [IW-1:0]         gnt_idx;
    logic                  gnt_any;

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] last, input int k);
        int unsigned s;
        s = (32'(last) + k) % NB_REQ;
        return IW'(s);
    endfunction

    // Scan from farthest to nearest so the first valid index after last_q wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = int'(NB_REQ); k >= 1; k--) begin
            if (req_valid_i[rr_idx(last_q, k)]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_idx(last_q, k);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (rstn_i && state_q == IDLE && gnt_any) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = '0;
        cfg_data_o  = '0;
        case (state_q)
            WR_EXT:  begin cfg_addr_o = A_EXT;  cfg_data_o = ext_q;                  end
            WR_L2:   begin cfg_addr_o = A_L2;   cfg_data_o = l2_q;                   end
            WR_SIZE: begin cfg_addr_o = A_SIZE; cfg_data_o = 32'(size_q);            end
            WR_CMD:  begin cfg_addr_o = A_CMD;  cfg_data_o = {30'd0, 1'b1, rwn_q};   end
            default: cfg_valid_o = 1'b0;
        endcase
    end

    assign cfg_rwn_o = 1'b0;
    assign busy_o    = (state_q != IDLE);
    // A coincident eot_i at the last count wins over the timeout.
    assign err_o     = (state_q == WAIT_EOT) && (&cnt_q) && !eot_i;
    assign done_o    = done_q;
    assign done_rd_o = done_rd_q;
    assign done_wr_o = done_wr_q;

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            last_q    <= IW'(NB_REQ - 1);
            idx_q     <= '0;
            ext_q     <= '0;
            l2_q      <= '0;
            size_q    <= '0;
            rwn_q     <= 1'b0;
            cnt_q     <= '0;
            done_q    <= '0;
            done_rd_q <= 1'b0;
            done_wr_q <= 1'b0;
        end else begin
            done_q    <= '0;
            done_rd_q <= 1'b0;
            done_wr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        idx_q   <= gnt_idx;
                        ext_q   <= req_ext_addr_i[gnt_idx];
                        l2_q    <= req_l2_addr_i[gnt_idx];
                        size_q  <= req_size_i[gnt_idx];
                        rwn_q   <= req_rwn_i[gnt_idx];
                        state_q <= (req_size_i[gnt_idx] == '0) ? DONE : WR_EXT;
                    end
                end
                WR_EXT:  if (cfg_ready_i) state_q <= WR_L2;
                WR_L2:   if (cfg_ready_i) state_q <= WR_SIZE;
                WR_SIZE: if (cfg_ready_i) state_q <= WR_CMD;
                WR_CMD: begin
                    if (cfg_ready_i) begin
                        state_q <= WAIT_EOT;
                        cnt_q   <= '0;
                    end
                end
                WAIT_EOT: begin
                    if (eot_i) begin
                        state_q <= DONE;
                    end else if (&cnt_q) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q[idx_q] <= 1'b1;
                    done_rd_q     <= rwn_q;
                    done_wr_q     <= !rwn_q;
                    last_q        <= idx_q;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udma_hyper_sched.sv
// Bench for udma_hyper_sched: directed scenarios and randomized transfers scored
// against a transaction-level model (round-robin pick, expected config writes).
`timescale 1ns/1ps
module tb_udma_hyper_sched;
    localparam int NB    = 3;
    localparam int TW    = 16;
    localparam int TMO   = 4;
    localparam int LIMIT = (1 << TMO) - 1;

    logic                  sys_clk = 1'b0;
    logic                  rstn;
    logic [NB-1:0]         req_valid, req_ready, req_rwn, done;
    logic [NB-1:0][31:0]   ext_addr, l2_addr;
    logic [NB-1:0][TW-1:0] req_size;
    logic [4:0]            cfg_addr;
    logic [31:0]           cfg_data;
    logic                  cfg_valid, cfg_rwn, cfg_ready, eot, done_rd, done_wr, err, busy;
    logic [2*NB+42:0]      outs;
    int                    checks = 0;
    int                    failures = 0;
    int                    m_last;

    assign outs = {req_ready, cfg_addr, cfg_data, cfg_valid, cfg_rwn, done, done_rd, done_wr, err, busy};
    always #5 sys_clk = ~sys_clk;

    udma_hyper_sched #(.NB_REQ(NB), .TRANS_SIZE(TW), .TMO_W(TMO)) dut (
        .sys_clk_i(sys_clk), .rstn_i(rstn),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_ext_addr_i(ext_addr), .req_l2_addr_i(l2_addr),
        .req_size_i(req_size), .req_rwn_i(req_rwn),
        .cfg_addr_o(cfg_addr), .cfg_data_o(cfg_data), .cfg_valid_o(cfg_valid),
        .cfg_rwn_o(cfg_rwn), .cfg_ready_i(cfg_ready), .eot_i(eot),
        .done_o(done), .done_rd_o(done_rd), .done_wr_o(done_wr),
        .err_o(err), .busy_o(busy)
    );

    // Reference: first valid requester after the last completed one, wrapping.
    function automatic int rr_pick(input logic [NB-1:0] mask, input int last);
        int idx = last;
        repeat (NB) begin
            idx = (idx == NB - 1) ? 0 : idx + 1;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [36:0] exp_write(input int i, input logic [31:0] e, input logic [31:0] l,
                                              input logic [TW-1:0] s, input logic r);
        case (i)
            0:       return {5'h00, e};
            1:       return {5'h01, l};
            2:       return {5'h02, 16'd0, s};
            default: return {5'h03, 30'd0, 1'b1, r};
        endcase
    endfunction

    function automatic int oh_idx(input logic [NB-1:0] v);
        int r = -1;
        for (int i = 0; i < NB; i++) if (v[i]) r = (r == -1) ? i : -2;
        return r;
    endfunction

    task automatic scramble();
        for (int i = 0; i < NB; i++) begin
            ext_addr[i] = $urandom;
            l2_addr[i]  = $urandom;
            req_size[i] = TW'($urandom_range(1, 65535));
            req_rwn[i]  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic apply_reset();
        @(negedge sys_clk);
        rstn = 1'b0; req_valid = '0; eot = 1'b0; cfg_ready = 1'b0;
        repeat (2) @(negedge sys_clk);
        rstn = 1'b1;
        m_last = NB - 1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; req_valid = '1; cfg_ready = 1'b1; eot = 1'b1;
        scramble();
        repeat (3) @(negedge sys_clk);
        #1;
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        @(negedge sys_clk);
        rstn = 1'b1; req_valid = '0; eot = 1'b0;
        #1;
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL reset_release: got %h expected 0", outs); end
        m_last = NB - 1;
    endtask

    task automatic test_basic();
        logic [36:0] ew [4];
        apply_reset();
        scramble();
        ext_addr[0] = 32'h0000_1000; l2_addr[0] = 32'h1C00_0000; req_size[0] = 16'h0040; req_rwn[0] = 1'b1;
        ew[0] = {5'h00, 32'h0000_1000}; ew[1] = {5'h01, 32'h1C00_0000};
        ew[2] = {5'h02, 32'h0000_0040}; ew[3] = {5'h03, 32'h0000_0003};
        @(negedge sys_clk);
        req_valid = NB'(1); cfg_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== NB'(1) || busy !== 1'b0) begin
            failures++; $display("FAIL basic_grant: req_ready=%b busy=%b expected 001 busy=0", req_ready, busy);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            req_valid = '0; scramble();
            #1;
            checks++;
            if ({cfg_valid, cfg_addr, cfg_data} !== {1'b1, ew[i]}) begin
                failures++;
                $display("FAIL basic_cfg%0d: valid=%b addr=%h data=%h expected addr/data %h", i, cfg_valid, cfg_addr, cfg_data, ew[i]);
            end
        end
        @(negedge sys_clk);
        eot = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1 || cfg_valid !== 1'b0) begin
            failures++; $display("FAIL basic_wait: busy=%b cfg_valid=%b expected 1/0", busy, cfg_valid);
        end
        @(negedge sys_clk);
        eot = 1'b0;
        @(negedge sys_clk);
        #1;
        checks++;
        if ({done, done_rd, done_wr, busy} !== {NB'(1), 1'b1, 1'b0, 1'b0}) begin
            failures++; $display("FAIL basic_done: done=%b rd=%b wr=%b busy=%b expected 001 1 0 0", done, done_rd, done_wr, busy);
        end
        m_last = 0;
    endtask

    task automatic test_back_to_back();
        int gseq[$];
        int dseq[$];
        int lst, eg, gv, dv, bad_oh;
        apply_reset();
        scramble();
        bad_oh = 0;
        for (int c = 0; c < 200 && dseq.size() < 4; c++) begin
            @(negedge sys_clk);
            req_valid = NB'(3); cfg_ready = 1'b1; eot = 1'b1;
            #1;
            if (oh_idx(req_ready) == -2) bad_oh++;
            if (req_ready !== '0) gseq.push_back(oh_idx(req_ready));
            if (done !== '0) dseq.push_back(oh_idx(done));
        end
        req_valid = '0; eot = 1'b0;
        checks++;
        if (bad_oh != 0) begin failures++; $display("FAIL b2b_onehot: %0d multi-grant cycles, required 0", bad_oh); end
        lst = NB - 1;
        for (int i = 0; i < 4; i++) begin
            eg = rr_pick(NB'(3), lst);
            lst = eg;
            gv = (i < gseq.size()) ? gseq[i] : -1;
            dv = (i < dseq.size()) ? dseq[i] : -1;
            checks++;
            if (gv != eg) begin failures++; $display("FAIL b2b_grant%0d: got %0d expected %0d", i, gv, eg); end
            checks++;
            if (dv != eg) begin failures++; $display("FAIL b2b_done%0d: got %0d expected %0d", i, dv, eg); end
        end
    endtask

    task automatic test_cfg_stall();
        logic [31:0] e_l2;
        logic [TW-1:0] e_size;
        logic e_rwn;
        apply_reset();
        scramble();
        e_l2 = l2_addr[1]; e_size = req_size[1]; e_rwn = req_rwn[1];
        @(negedge sys_clk);
        req_valid = NB'(2); cfg_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== NB'(2)) begin failures++; $display("FAIL stall_grant: got %b expected 010", req_ready); end
        @(negedge sys_clk);
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            cfg_ready = (i == 3);
            #1;
            checks++;
            if ({cfg_valid, cfg_addr, cfg_data} !== {1'b1, 5'h01, e_l2}) begin
                failures++; $display("FAIL stall_hold%0d: valid=%b addr=%h data=%h expected 1 01 %h", i, cfg_valid, cfg_addr, cfg_data, e_l2);
            end
        end
        @(negedge sys_clk);
        #1;
        checks++;
        if ({cfg_valid, cfg_addr, cfg_data} !== {1'b1, 5'h02, 16'd0, e_size}) begin
            failures++; $display("FAIL stall_next: valid=%b addr=%h data=%h expected 1 02 %h", cfg_valid, cfg_addr, cfg_data, e_size);
        end
        @(negedge sys_clk);
        @(negedge sys_clk);
        eot = 1'b1;
        @(negedge sys_clk);
        eot = 1'b0;
        @(negedge sys_clk);
        #1;
        checks++;
        if ({done, done_rd, done_wr} !== {NB'(2), e_rwn, ~e_rwn}) begin
            failures++; $display("FAIL stall_done: done=%b rd=%b wr=%b expected 010 %b %b", done, done_rd, done_wr, e_rwn, ~e_rwn);
        end
        m_last = 1;
    endtask

    task automatic test_timeout();
        int g, g2;
        logic e_rwn;
        apply_reset();
        scramble();
        g = $urandom_range(0, 1);
        @(negedge sys_clk);
        req_valid = NB'(1) << g; cfg_ready = 1'b1; eot = 1'b0;
        #1;
        checks++;
        if (req_ready !== (NB'(1) << g)) begin failures++; $display("FAIL to_grant: got %b expected req %0d", req_ready, g); end
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            req_valid = '0; eot = 1'b1;
        end
        for (int j = 0; j <= LIMIT; j++) begin
            @(negedge sys_clk);
            eot = 1'b0;
            #1;
            checks++;
            if (err !== (j == LIMIT) || busy !== 1'b1 || done !== '0) begin
                failures++; $display("FAIL to_wait%0d: err=%b busy=%b done=%b expected err=%0d busy=1 done=0", j, err, busy, done, j == LIMIT);
            end
        end
        @(negedge sys_clk);
        #1;
        checks++;
        if ({err, busy, done, done_rd, done_wr} !== '0) begin
            failures++; $display("FAIL to_after: err=%b busy=%b done=%b rd=%b wr=%b expected all 0", err, busy, done, done_rd, done_wr);
        end
        @(negedge sys_clk);
        req_valid = '1;
        #1;
        g2 = rr_pick({NB{1'b1}}, m_last);
        e_rwn = req_rwn[g2];
        checks++;
        if (req_ready !== (NB'(1) << g2) || done !== '0) begin
            failures++; $display("FAIL to_next_grant: req_ready=%b done=%b expected req %0d done 0", req_ready, done, g2);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            req_valid = '0;
        end
        for (int j = 0; j <= LIMIT; j++) begin
            @(negedge sys_clk);
            eot = (j == LIMIT);
        end
        #1;
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL eot_limit_err: err=%b expected 0", err); end
        @(negedge sys_clk);
        eot = 1'b0;
        @(negedge sys_clk);
        #1;
        checks++;
        if ({done, done_rd, done_wr, err} !== {NB'(1) << g2, e_rwn, ~e_rwn, 1'b0}) begin
            failures++; $display("FAIL eot_limit_done: done=%b rd=%b wr=%b err=%b expected req %0d", done, done_rd, done_wr, err, g2);
        end
        m_last = g2;
    endtask

    task automatic test_zero_size();
        logic [NB-1:0] mask, oh;
        int g;
        scramble();
        for (int i = 0; i < NB; i++) begin req_size[i] = '0; req_rwn[i] = 1'b0; end
        mask = NB'($urandom_range(1, (1 << NB) - 1));
        g = rr_pick(mask, m_last);
        oh = NB'(1) << g;
        @(negedge sys_clk);
        req_valid = mask; cfg_ready = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if (req_ready !== oh) begin failures++; $display("FAIL zero_grant: got %b expected %b", req_ready, oh); end
        @(negedge sys_clk);
        req_valid = '0;
        #1;
        checks++;
        if (cfg_valid !== 1'b0 || busy !== 1'b1 || done !== '0) begin
            failures++; $display("FAIL zero_state: cfg_valid=%b busy=%b done=%b expected 0 1 0", cfg_valid, busy, done);
        end
        @(negedge sys_clk);
        #1;
        checks++;
        if ({done, done_wr, done_rd, cfg_valid} !== {oh, 1'b1, 1'b0, 1'b0}) begin
            failures++; $display("FAIL zero_done: done=%b wr=%b rd=%b cfg_valid=%b expected %b 1 0 0", done, done_wr, done_rd, cfg_valid, oh);
        end
        m_last = g;
    endtask

    task automatic test_reset_mid();
        scramble();
        @(negedge sys_clk);
        req_valid = NB'(1); cfg_ready = 1'b1; eot = 1'b0;
        repeat (6) @(negedge sys_clk);
        req_valid = '0;
        #1;
        checks++;
        if (busy !== 1'b1 || cfg_valid !== 1'b0) begin
            failures++; $display("FAIL rst_mid_wait: busy=%b cfg_valid=%b expected 1 0", busy, cfg_valid);
        end
        @(negedge sys_clk);
        rstn = 1'b0;
        #1;
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL rst_mid_outputs: got %h expected 0", outs); end
        @(negedge sys_clk);
        rstn = 1'b1; eot = 1'b1; m_last = NB - 1;
        @(negedge sys_clk);
        eot = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            #1;
            checks++;
            if (outs !== '0) begin failures++; $display("FAIL rst_mid_quiet%0d: got %h expected 0", i, outs); end
        end
        @(negedge sys_clk);
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== NB'(1)) begin failures++; $display("FAIL rst_mid_regrant: got %b expected 001", req_ready); end
        apply_reset();
    endtask

    task automatic test_random();
        logic [NB-1:0] mask, oh;
        logic [31:0] e_ext, e_l2;
        logic [TW-1:0] e_size;
        logic e_rwn;
        logic [36:0] got [4];
        int g, nw, cyc, d, side;
        for (int t = 0; t < 40; t++) begin
            @(negedge sys_clk);
            scramble();
            if ($urandom_range(0, 5) == 0) for (int i = 0; i < NB; i++) req_size[i] = '0;
            mask = NB'($urandom_range(1, (1 << NB) - 1));
            req_valid = mask; eot = 1'($urandom_range(0, 1)); cfg_ready = 1'($urandom_range(0, 1));
            #1;
            g = rr_pick(mask, m_last);
            oh = NB'(1) << g;
            e_ext = ext_addr[g]; e_l2 = l2_addr[g]; e_size = req_size[g]; e_rwn = req_rwn[g];
            checks++;
            if (req_ready !== oh || busy !== 1'b0) begin
                failures++; $display("FAIL rand_grant t=%0d: req_ready=%b busy=%b expected %b busy=0", t, req_ready, busy, oh);
            end
            side = 0;
            if (e_size != '0) begin
                nw = 0; cyc = 0;
                while (nw < 4 && cyc < 60) begin
                    @(negedge sys_clk);
                    scramble();
                    req_valid = NB'($urandom); cfg_ready = 1'($urandom_range(0, 1)); eot = 1'($urandom_range(0, 1));
                    #1;
                    if (req_ready !== '0 || done !== '0 || err !== 1'b0 || cfg_valid !== 1'b1 || cfg_rwn !== 1'b0) side++;
                    if (cfg_ready) begin got[nw] = {cfg_addr, cfg_data}; nw++; end
                    cyc++;
                end
                checks++;
                if (nw != 4) begin failures++; $display("FAIL rand_cfg_count t=%0d: got %0d writes expected 4", t, nw); end
                for (int i = 0; i < nw; i++) begin
                    checks++;
                    if (got[i] !== exp_write(i, e_ext, e_l2, e_size, e_rwn)) begin
                        failures++;
                        $display("FAIL rand_cfg t=%0d w=%0d: got %h expected %h", t, i, got[i], exp_write(i, e_ext, e_l2, e_size, e_rwn));
                    end
                end
                d = $urandom_range(0, LIMIT);
                for (int j = 0; j <= d; j++) begin
                    @(negedge sys_clk);
                    eot = (j == d); req_valid = NB'($urandom); cfg_ready = 1'($urandom_range(0, 1));
                    #1;
                    if (busy !== 1'b1 || err !== 1'b0 || cfg_valid !== 1'b0 || req_ready !== '0 || done !== '0) side++;
                end
            end
            @(negedge sys_clk);
            req_valid = NB'($urandom); eot = 1'($urandom_range(0, 1));
            #1;
            if (busy !== 1'b1 || done !== '0 || cfg_valid !== 1'b0 || req_ready !== '0 || err !== 1'b0) side++;
            checks++;
            if (side != 0) begin failures++; $display("FAIL rand_side t=%0d: %0d bad cycles expected 0", t, side); end
            @(negedge sys_clk);
            req_valid = '0; eot = 1'b0;
            #1;
            checks++;
            if ({done, done_rd, done_wr, busy, err} !== {oh, e_rwn, ~e_rwn, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL rand_done t=%0d: done=%b rd=%b wr=%b busy=%b err=%b expected %b %b %b 0 0", t, done, done_rd, done_wr, busy, err, oh, e_rwn, ~e_rwn);
            end
            m_last = g;
        end
    endtask

    initial begin
        rstn = 1'b0; req_valid = '0; eot = 1'b0; cfg_ready = 1'b0;
        ext_addr = '0; l2_addr = '0; req_size = '0; req_rwn = '0;
        m_last = NB - 1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_cfg_stall();
        test_timeout();
        test_zero_size();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
